// File: rtl/stable_pkg.sv
// Shared types and defaults for the stable hold driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stable_pkg;

    // IDLE accepts a new value; HOLD blocks until the hold window expires.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

    localparam int DEFAULT_MIN_HOLD = 4;

    // Width of a counter that must represent 0..min_hold.
    function automatic int hold_cnt_width(input int min_hold);
        return $clog2(min_hold + 1);
    endfunction

endpackage

// File: rtl/stable_hold_driver_hold_timer.sv
// Hold-window down-counter: load, decrement, zero flag.
// Latency: load/decrement visible one clock after the requesting edge.
// Backpressure: none; it never goes below zero even if decrement is held.
module hold_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; count floors at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/stable_hold_driver.sv
// Drives a registered output that never changes twice within MIN_HOLD clocks.
// Latency: accepted value appears on out_data one clock after the transfer edge.
// Backpressure: in_ready drops for MIN_HOLD-1 clocks after each change; held values wait.
module stable_hold_driver
    import stable_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter int               MIN_HOLD = DEFAULT_MIN_HOLD,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            in_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_stable,
    output logic                            out_changed,
    output logic [$clog2(MIN_HOLD+1)-1:0]   hold_cnt,
    output logic [15:0]                     change_cnt
);

    localparam int CNT_W = hold_cnt_width(MIN_HOLD);

    hold_state_e      r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_prev_data;
    logic [15:0]      r_change_cnt;

    logic             w_xfer;
    logic             w_change;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;
    logic [CNT_W-1:0] w_hold_cnt;

    // in_ready depends on state only, never on in_valid.
    assign in_ready = (r_state == IDLE);
    assign w_xfer   = in_valid && in_ready;
    // Gating by w_xfer keeps an X on in_data (with in_valid low) away from out_data.
    assign w_change = w_xfer && (in_data != r_out_data);
    // A one-clock hold needs no window: the driver stays in IDLE.
    assign w_load   = w_change && (MIN_HOLD > 1);
    assign w_dec    = (r_state == HOLD) && !w_zero;

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (CNT_W'(MIN_HOLD - 1)),
        .i_dec      (w_dec),
        .o_cnt      (w_hold_cnt),
        .o_zero     (w_zero)
    );

    // State, driven value, previous value and saturating change counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_out_data   <= INIT_VAL;
            r_prev_data  <= INIT_VAL;
            r_change_cnt <= '0;
        end else begin
            r_prev_data <= r_out_data;
            case (r_state)
                IDLE: begin
                    if (w_change) begin
                        r_out_data <= in_data;
                        if (r_change_cnt != 16'hFFFF) begin
                            r_change_cnt <= r_change_cnt + 16'd1;
                        end
                        if (MIN_HOLD > 1) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_hold_cnt == CNT_W'(1)) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign out_data    = r_out_data;
    assign out_stable  = (r_out_data == r_prev_data);
    assign out_changed = !out_stable;
    assign hold_cnt    = w_hold_cnt;
    assign change_cnt  = r_change_cnt;

endmodule

// File: tb/tb_stable_hold_driver.sv
module tb_stable_hold_driver;

    localparam int MH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [0:0]  in_data;
    logic        in_ready;
    logic [0:0]  out_data;
    logic        out_stable;
    logic        out_changed;
    logic [2:0]  hold_cnt;
    logic [15:0] change_cnt;

    logic        rst8_n;
    logic        v8;
    logic [7:0]  d8;
    logic        rdy8;
    logic [7:0]  out8;
    logic        stable8;
    logic        chg8;
    logic [0:0]  hold8;
    logic [15:0] cnt8;

    int n_checks = 0;
    int n_fail   = 0;

    stable_hold_driver #(.WIDTH(1), .MIN_HOLD(MH), .INIT_VAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_data(out_data), .out_stable(out_stable),
        .out_changed(out_changed), .hold_cnt(hold_cnt), .change_cnt(change_cnt)
    );

    stable_hold_driver #(.WIDTH(8), .MIN_HOLD(1), .INIT_VAL(8'h00)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(v8), .in_data(d8),
        .in_ready(rdy8), .out_data(out8), .out_stable(stable8),
        .out_changed(chg8), .hold_cnt(hold8), .change_cnt(cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time-based view of the rule "no two changes closer than MH edges".
    logic [0:0] m_out;
    int         m_edge;
    int         m_last_chg;
    int         m_cnt;

    task automatic model_reset();
        m_out      = 1'b0;
        m_edge     = 0;
        m_last_chg = -1000;
        m_cnt      = 0;
    endtask

    function automatic bit m_ready();
        return (m_edge - m_last_chg) >= MH;
    endfunction

    // Called at a negedge: check outputs against the model, drive, advance one edge.
    task automatic cycle(input logic v, input logic [0:0] d);
        bit rdy;
        bit chg;
        int hold;
        rdy  = m_ready();
        chg  = (m_last_chg == m_edge - 1);
        hold = m_last_chg + MH - m_edge;
        if (hold < 0) hold = 0;
        chk("in_ready",    32'(in_ready),    32'(rdy));
        chk("out_data",    32'(out_data),    32'(m_out));
        chk("out_changed", 32'(out_changed), 32'(chg));
        chk("out_stable",  32'(out_stable),  32'(!chg));
        chk("hold_cnt",    32'(hold_cnt),    32'(hold));
        chk("change_cnt",  32'(change_cnt),  32'(m_cnt));
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (v && rdy && (d !== m_out)) begin
            m_out      = d;
            m_last_chg = m_edge;
            if (m_cnt < 65535) m_cnt++;
        end
        m_edge++;
        @(negedge clk);
    endtask

    // Hold-window watcher: every observed change must be >= MH edges after the previous one.
    logic [0:0] w_last;
    int         w_gap;
    always @(negedge clk) begin
        if (!rst_n) begin
            w_last = out_data;
            w_gap  = MH;
        end else if (out_data !== w_last) begin
            chk("hold_window_gap", 32'(w_gap >= MH), 32'd1);
            w_last = out_data;
            w_gap  = 1;
        end else begin
            w_gap++;
        end
    end

    typedef struct {
        logic       v;
        logic [0:0] d;
        logic       e_rdy;
        logic [0:0] e_out;
        logic       e_chg;
        int         e_hold;
        int         e_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:0] d;
        logic [7:0] sb8_out;
        int         sb8_cnt;
        bit         sb8_chg;

        // Expected outputs observed at each negedge before that row's inputs are applied.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};

        rst_n    = 1'b0;
        rst8_n   = 1'b0;
        in_valid = 1'b0;
        in_data  = 1'b0;
        v8       = 1'b0;
        d8       = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        rst8_n = 1'b1;

        // Reset idle, single change with its hold window, then a same-value send.
        for (int i = 0; i < 10; i++) begin
            chk("tbl_out_data",   32'(out_data),    32'(tbl[i].e_out));
            chk("tbl_in_ready",   32'(in_ready),    32'(tbl[i].e_rdy));
            chk("tbl_out_change", 32'(out_changed), 32'(tbl[i].e_chg));
            chk("tbl_out_stable", 32'(out_stable),  32'(!tbl[i].e_chg));
            chk("tbl_hold_cnt",   32'(hold_cnt),    32'(tbl[i].e_hold));
            chk("tbl_change_cnt", 32'(change_cnt),  32'(tbl[i].e_cnt));
            cycle(tbl[i].v, tbl[i].d);
        end

        // Producer streams alternating values every clock.
        d = ~m_out;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, d);
            d = ~d;
        end

        // X on in_data with in_valid low must not reach out_data.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'bx);

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset two clocks into a hold window.
        for (int i = 0; i < MH && !m_ready(); i++) cycle(1'b0, 1'b0);
        cycle(1'b1, ~m_out);
        cycle(1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_data",   32'(out_data),    32'd0);
        chk("rst_in_ready",   32'(in_ready),    32'd1);
        chk("rst_out_stable", 32'(out_stable),  32'd1);
        chk("rst_out_change", 32'(out_changed), 32'd0);
        chk("rst_hold_cnt",   32'(hold_cnt),    32'd0);
        chk("rst_change_cnt", 32'(change_cnt),  32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cycle(1'b1, 1'b1);
        chk("post_rst_out_data", 32'(out_data), 32'd1);
        chk("post_rst_hold_cnt", 32'(hold_cnt), 32'd3);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        // MIN_HOLD=1, WIDTH=8: always ready, every differing valid value is a change.
        sb8_out = 8'h00;
        sb8_cnt = 0;
        sb8_chg = 1'b0;
        for (int i = 0; i < 200; i++) begin
            chk("w8_in_ready",    32'(rdy8),  32'd1);
            chk("w8_out_data",    32'(out8),  32'(sb8_out));
            chk("w8_out_changed", 32'(chg8),  32'(sb8_chg));
            chk("w8_change_cnt",  32'(cnt8),  32'(sb8_cnt));
            v8 = 1'($urandom_range(0, 1));
            d8 = 8'($urandom_range(0, 3));
            @(posedge clk);
            sb8_chg = v8 && (d8 != sb8_out);
            if (sb8_chg) begin
                sb8_out = d8;
                sb8_cnt++;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
